wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result (load data or ALU result) and commits it into a 32x32 general-purpose register file.
- Serves the two decode-stage read ports.
- Exports the selected result for EX-stage forwarding and keeps a retired-write counter for debug/perf.

Parameters:
- DATA_W, 32, register and result width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 32, width of retired-write counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RegWriteW  in  1  writeback enable from MEM/WB
- MemtoRegW  in  1  1 = write ReadDataW, 0 = write ALUResultW
- ReadDataW  in  DATA_W  load data from MEM/WB
- ALUResultW  in  DATA_W  ALU result from MEM/WB
- RegDstW  in  ADDR_W  destination register
- RsD  in  ADDR_W  decode read address 1
- RtD  in  ADDR_W  decode read address 2
- RD1  out  DATA_W  read data 1 (combinational)
- RD2  out  DATA_W  read data 2 (combinational)
- ResultW  out  DATA_W  selected writeback value (combinational, for forwarding)
- WriteCount  out  CNT_W  number of committed register writes

Behaviour:
- Reset: clk and rst are already decided, exactly: reset rst, synchronous, active-high; clock clk.
  - rst=1 at a rising edge clears all NUM_REGS registers to 0 and clears WriteCount to 0.
  - RD1/RD2 read 0 after reset; ResultW still follows its inputs combinationally.
- ResultW = MemtoRegW ? ReadDataW : ALUResultW. Pure mux, no latency.
- Commit: at rising edge with rst=0, RegWriteW=1 and RegDstW!=0, reg[RegDstW] <= ResultW.
  - One-cycle latency: the value is architecturally visible from the next cycle.
- Register 0 is hardwired to 0.
  - Writes to address 0 are dropped and do not increment WriteCount.
  - RD1/RD2 for address 0 return 0 always.
- Reads are asynchronous: RD1 = reg[RsD], RD2 = reg[RtD], subject to the bypass rule under Optional Feature.
- WriteCount increments by 1 on each committed write (same condition as commit). It saturates at all-ones and never wraps.
- RegWriteW=0: no register change, no count change; MemtoRegW, data and address are don't-care.
- RsD==RtD: both ports return the identical value.
- rst asserted concurrently with a valid write: reset wins, the write is lost, and the count stays 0.
- No X propagation: all storage is initialised by reset, with no reliance on initial blocks.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: same-cycle write-to-read bypass.
  - If RegWriteW=1, RegDstW!=0 and RsD==RegDstW, then RD1=ResultW. Same rule for RtD/RD2.
  - Removes the WB->ID hazard without a split-cycle register file.
- Undefined: RD1/RD2 return the stored (pre-write) value during the write cycle.
  - The hazard unit must stall or forward for that one cycle.

Decomposition:
- Shared package (datapath_pkg), reused by the pipeline registers, hazard and forwarding units:
  - DATA_W, ADDR_W, NUM_REGS
  - ZERO_REG = 5'd0
  - WB control bit indices: WB_REGWRITE=0, WB_MEMTOREG=1
- Sub-module wb_regfile_array holds the storage.
  - Contents: NUM_REGS x DATA_W, synchronous reset, one write port, two async read ports, zero-register masking.
  - The top level holds the result mux, the bypass logic and WriteCount.

Test Plan:
- Reset then read: rst=1 one cycle, RsD=5, RtD=31 -> RD1=0, RD2=0, WriteCount=0.
- ALU writeback: RegWriteW=1, MemtoRegW=0, ALUResultW=32'h0000_1234, RegDstW=8 -> ResultW=32'h1234 same cycle; next cycle RsD=8 gives RD1=32'h1234; WriteCount=1.
- Load writeback plus zero register:
  - MemtoRegW=1, ReadDataW=32'hDEAD_BEEF, RegDstW=9 -> RtD=9 next cycle gives RD2=32'hDEADBEEF.
  - Then RegDstW=0, ALUResultW=32'hFFFF_FFFF -> RsD=0 gives RD1=0, WriteCount unchanged at 2.
- Same-cycle hazard: reg10=32'h1, then write 32'h2 to reg10 while RsD=10.
  - With WB_BYPASS_EN: RD1=32'h2 in that cycle.
  - Without it: RD1=32'h1 in that cycle.
  - Both builds: RD1=32'h2 next cycle.
- Reset mid-operation: valid write of 32'hA5A5 to reg3 in the same cycle as rst=1 -> next cycle RsD=3 gives RD1=0, WriteCount=0.
- Counter saturation: force WriteCount to all-ones (CNT_W=4 build: 15), perform one more write -> WriteCount stays 15 and the register still updates.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants for the pipeline registers, hazard/forwarding units
// and the writeback register file.
package datapath_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // Bit positions inside the packed WB control field carried by MEM/WB.
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef logic [1:0] wb_ctrl_t;

endpackage

// File: rtl/wb_regfile_array.sv
// Register storage: NUM_REGS x DATA_W, synchronous reset, one write port,
// two asynchronous read ports, register 0 reads as zero and is never stored.
module wb_regfile_array #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import datapath_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf [NUM_REGS];

  assign rf[0] = '0;

  // Each register is its own flop group so reset can clear them all at once.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign rf[gi] = q_reg;
    end
  endgenerate

  assign rdata1 = (raddr1 == ZERO_ADDR) ? '0 : rf[raddr1];
  assign rdata2 = (raddr2 == ZERO_ADDR) ? '0 : rf[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register file commit, decode read ports and
// a saturating retired-write counter. Optional same-cycle bypass: WB_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [ADDR_W-1:0] RegDstW,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] ResultW,
  output logic [CNT_W-1:0]  WriteCount
);
  import datapath_pkg::*;

  wb_ctrl_t          wb_ctrl;
  logic              commit;
  logic [DATA_W-1:0] rd1_arr;
  logic [DATA_W-1:0] rd2_arr;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    wb_ctrl              = '0;
    wb_ctrl[WB_REGWRITE] = RegWriteW;
    wb_ctrl[WB_MEMTOREG] = MemtoRegW;
  end

  assign ResultW = wb_ctrl[WB_MEMTOREG] ? ReadDataW : ALUResultW;
  assign commit  = wb_ctrl[WB_REGWRITE] && (RegDstW != ADDR_W'(ZERO_REG));

  wb_regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (RegDstW),
    .wdata  (ResultW),
    .raddr1 (RsD),
    .raddr2 (RtD),
    .rdata1 (rd1_arr),
    .rdata2 (rd2_arr)
  );

`ifdef WB_BYPASS_EN
  // Forward the in-flight write so decode never sees the stale value.
  assign RD1 = (commit && (RsD == RegDstW)) ? ResultW : rd1_arr;
  assign RD2 = (commit && (RtD == RegDstW)) ? ResultW : rd2_arr;
`else
  assign RD1 = rd1_arr;
  assign RD2 = rd2_arr;
`endif

  always_comb begin
    count_next = count_reg;
    if (commit && !(&count_reg)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign WriteCount = count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile (4-bit counter build so saturation is reachable);
// expectations for the write cycle follow WB_BYPASS_EN.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUResultW;
  logic [4:0]  RegDstW;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [3:0]  WriteCount;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [32];
  logic [3:0]  cnt_m;

  wb_regfile #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_REGS (32),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .RegDstW    (RegDstW),
    .RsD        (RsD),
    .RtD        (RtD),
    .RD1        (RD1),
    .RD2        (RD2),
    .ResultW    (ResultW),
    .WriteCount (WriteCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic we,
                                           input logic [4:0] dst, input logic [31:0] res);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && dst != 5'd0 && a == dst) return res;
`endif
    return mem_m[a];
  endfunction

  // One clock: drive at negedge, push expectation, compare 1ns later, update model at posedge.
  task automatic step(input string tag, input logic r, input logic we, input logic m2r,
                      input logic [31:0] rdata, input logic [31:0] alu,
                      input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                      input bit chk);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; RegWriteW = we; MemtoRegW = m2r;
    ReadDataW = rdata; ALUResultW = alu; RegDstW = dst; RsD = rs; RtD = rt;
    e.tag = tag;
    e.res = m2r ? rdata : alu;
    e.rd1 = model_rd(rs, we, dst, e.res);
    e.rd2 = model_rd(rt, we, dst, e.res);
    e.cnt = cnt_m;
    if (chk) sb_q.push_back(e);
    #1;
    if (chk) begin
      got = sb_q.pop_front();
      $display("txn %s rst=%0b we=%0b dst=%0d rs=%0d rt=%0d rd1=%h rd2=%h res=%h cnt=%0d",
               got.tag, r, we, dst, rs, rt, RD1, RD2, ResultW, WriteCount);
      check({got.tag, ".rd1"}, RD1, got.rd1);
      check({got.tag, ".rd2"}, RD2, got.rd2);
      check({got.tag, ".res"}, ResultW, got.res);
      check({got.tag, ".cnt"}, {28'h0, WriteCount}, {28'h0, got.cnt});
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
      cnt_m = 4'd0;
    end else if (we && dst != 5'd0) begin
      mem_m[dst] = e.res;
      if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    cnt_m = 4'd0;

    // Reset, then read two addresses
    step("rst0", 1, 0, 0, 0, 0, 0, 5, 31, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 5, 31, 1);
    step("rst_rd", 0, 0, 0, 0, 0, 0, 5, 31, 1);
    #1;
    check("rst_rd1", RD1, 32'h0);
    check("rst_rd2", RD2, 32'h0);
    check("rst_cnt", {28'h0, WriteCount}, 32'h0);

    // ALU writeback
    step("alu_wr", 0, 1, 0, 32'h0BAD_0BAD, 32'h0000_1234, 8, 8, 0, 1);
    step("alu_rd", 0, 0, 0, 0, 0, 0, 8, 0, 1);
    #1;
    check("alu_rd1", RD1, 32'h0000_1234);
    check("alu_cnt", {28'h0, WriteCount}, 32'd1);

    // Load writeback, then dropped write to r0
    step("ld_wr", 0, 1, 1, 32'hDEAD_BEEF, 32'h1111_1111, 9, 0, 9, 1);
    step("ld_rd", 0, 0, 0, 0, 0, 0, 0, 9, 1);
    #1;
    check("ld_rd2", RD2, 32'hDEAD_BEEF);
    step("r0_wr", 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 9, 1);
    step("r0_rd", 0, 0, 0, 0, 0, 0, 0, 9, 1);
    #1;
    check("r0_rd1", RD1, 32'h0);
    check("r0_cnt", {28'h0, WriteCount}, 32'd2);

    // Same-cycle write/read hazard on r10, both ports on the same address
    step("hz_wr1", 0, 1, 0, 0, 32'h1, 10, 0, 0, 1);
    step("hz_wr2", 0, 1, 0, 0, 32'h2, 10, 10, 10, 1);
    step("hz_rd", 0, 0, 0, 0, 0, 0, 10, 10, 1);
    #1;
    check("hz_rd1", RD1, 32'h2);
    check("hz_rd2", RD2, 32'h2);

    // Reset beats a concurrent valid write
    step("rst_wr", 1, 1, 0, 0, 32'hA5A5, 3, 3, 10, 1);
    step("rst_wr_rd", 0, 0, 0, 0, 0, 0, 3, 10, 1);
    #1;
    check("rstwr_rd1", RD1, 32'h0);
    check("rstwr_rd2", RD2, 32'h0);
    check("rstwr_cnt", {28'h0, WriteCount}, 32'h0);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      step("rand", 0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           $urandom, $urandom, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
    end

    // Push the counter to saturation, then one more write must still land
    for (int i = 1; i <= 16; i++) begin
      step("sat_fill", 0, 1, 0, 0, 32'h100 + i, 5'(i), 5'(i), 0, 1);
    end
    #1;
    check("sat_cnt", {28'h0, WriteCount}, 32'd15);
    step("sat_wr", 0, 1, 0, 0, 32'h7777_0007, 7, 0, 0, 1);
    step("sat_rd", 0, 0, 0, 0, 0, 0, 7, 16, 1);
    #1;
    check("sat_rd1", RD1, 32'h7777_0007);
    check("sat_rd2", RD2, 32'h0000_0110);
    check("sat_hold", {28'h0, WriteCount}, 32'd15);

    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
